// File: rtl/rotary_encoder.sv
// Quadrature rotary-encoder front end: sync, debounce, CK-edge decode, signed 8-bit delta with read-and-clear.
// Optional ROTARY_ENC_SATURATE_EN clamps the accumulator at +127/-128 instead of wrapping.
module rotary_encoder #(
    parameter int unsigned CYCLES = 1000
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic              ck,
    input  logic              dt,
    input  logic              read_enable,
    output logic signed [7:0] out
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    // Lane 0 carries CK, lane 1 carries DT.
    logic [1:0]       w_raw;
    logic [1:0]       r_meta;
    logic [1:0]       r_sync;
    logic [1:0]       r_deb;
    logic [CNT_W-1:0] r_stab [2];

    logic              r_ck_prev;
    logic              r_re;
    logic              r_re_d;
    logic signed [7:0] r_count;

    logic              w_ck_edge;
    logic signed [1:0] w_step;
    logic signed [7:0] w_next;
    logic              w_read;

    assign w_raw = {dt, ck};

    // Two-flop synchronizers followed by per-lane stability counters.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_deb  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_stab[i] <= '0;
            end
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_deb[i]) begin
                    r_stab[i] <= '0;
                end else if (r_stab[i] == CNT_LAST) begin
                    r_deb[i]  <= r_sync[i];
                    r_stab[i] <= '0;
                end else begin
                    r_stab[i] <= r_stab[i] + CNT_W'(1);
                end
            end
        end
    end

    // Any debounced CK edge is one step; direction from DT matching the new CK level.
    always_comb begin
        w_ck_edge = r_deb[0] ^ r_ck_prev;
        w_step    = 2'sd0;
        if (w_ck_edge) begin
            w_step = (r_deb[1] == r_deb[0]) ? 2'sd1 : -2'sd1;
        end
    end

`ifdef ROTARY_ENC_SATURATE_EN
    logic signed [8:0] w_wide;

    always_comb begin
        w_wide = {r_count[7], r_count} + {{7{w_step[1]}}, w_step};
        if (w_wide > 9'sd127) begin
            w_next = 8'sd127;
        end else if (w_wide < -9'sd128) begin
            w_next = -8'sd128;
        end else begin
            w_next = w_wide[7:0];
        end
    end
`else
    always_comb begin
        w_next = r_count + {{6{w_step[1]}}, w_step};
    end
`endif

    assign w_read = r_re & ~r_re_d;

    // Accumulate every cycle; a read rise hands the running total (including this cycle's step) to out.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_ck_prev <= 1'b0;
            r_re      <= 1'b0;
            r_re_d    <= 1'b0;
            r_count   <= '0;
            out       <= '0;
        end else begin
            r_ck_prev <= r_deb[0];
            r_re      <= read_enable;
            r_re_d    <= r_re;
            if (w_read) begin
                out     <= w_next;
                r_count <= '0;
            end else begin
                r_count <= w_next;
            end
        end
    end

endmodule

// File: tb/tb_rotary_encoder.sv
// Randomized self-checking bench for rotary_encoder against an encoder-line motion model.
module tb_rotary_encoder;

    localparam int unsigned CYC    = 16;
    localparam int          SETTLE = CYC + 8;

    logic              aclk = 1'b0;
    logic              reset;
    logic              ck;
    logic              dt;
    logic              read_enable;
    logic signed [7:0] out;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: settled encoder line levels and accumulated motion since the last read.
    logic m_ck;
    logic m_dt;
    int   m_acc;

    rotary_encoder #(.CYCLES(CYC)) dut (
        .aclk        (aclk),
        .reset       (reset),
        .ck          (ck),
        .dt          (dt),
        .read_enable (read_enable),
        .out         (out)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int apply_step(input int acc, input int step);
        int   s;
        byte  b;
        s = acc + step;
`ifdef ROTARY_ENC_SATURATE_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s;
`else
        b = 8'(s);
        return int'(b);
`endif
    endfunction

    function automatic int step_of(input logic nck, input logic ndt);
        if (nck == m_ck) return 0;
        return (ndt == nck) ? 1 : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic move(input logic nck, input logic ndt);
        int step;
        step = step_of(nck, ndt);
        m_ck = nck;
        m_dt = ndt;
        ck   = nck;
        dt   = ndt;
        tick(SETTLE);
        m_acc = apply_step(m_acc, step);
    endtask

    task automatic move_fwd();
        move(~m_ck, ~m_ck);
    endtask

    task automatic do_read(input string tag);
        read_enable = 1'b1;
        tick(4);
        check(tag, int'(out), m_acc);
        m_acc = 0;
        read_enable = 1'b0;
        tick(2);
    endtask

    task automatic glitch(input logic on_ck, input int len);
        if (on_ck) ck = ~ck; else dt = ~dt;
        tick(len);
        ck = m_ck;
        dt = m_dt;
        tick(SETTLE);
    endtask

    task automatic do_reset(input logic lck, input logic ldt);
        reset = 1'b1;
        ck    = lck;
        dt    = ldt;
        read_enable = 1'b0;
        tick(3);
        reset = 1'b0;
        m_ck  = 1'b0;
        m_dt  = 1'b0;
        m_acc = 0;
    endtask

    initial begin
        int held;
        int r1;
        int r2;
        int exp_sum;
        int ovf_exp;

        reset = 1'b1;
        ck = 1'b0;
        dt = 1'b0;
        read_enable = 1'b0;
        m_ck = 1'b0;
        m_dt = 1'b0;
        m_acc = 0;

        do_reset(1'b0, 1'b0);
        check("rst_out", int'(out), 0);
        do_read("rd_idle");

        move(1'b1, 1'b1);
        do_read("fwd");
        do_read("no_motion");

        move(1'b0, 1'b1);
        do_read("back");

        move(1'b1, 1'b1);
        move(1'b0, 1'b0);
        do_read("two_fwd");

        glitch(1'b1, CYC / 2);
        glitch(1'b0, CYC - 1);
        do_read("glitch");

        // Holding read_enable high must neither re-read nor clear again.
        move_fwd();
        read_enable = 1'b1;
        tick(4);
        held = m_acc;
        check("hold_first", int'(out), held);
        m_acc = 0;
        move_fwd();
        move(~m_ck, m_dt);
        check("hold_no_reread", int'(out), held);
        read_enable = 1'b0;
        tick(2);
        do_read("after_hold");

        // A step landing near the read rise goes to this read or the next, never lost.
        for (int d = CYC - 2; d <= CYC + 6; d++) begin
            exp_sum = step_of(~m_ck, m_dt);
            m_ck = ~m_ck;
            ck   = m_ck;
            tick(d);
            read_enable = 1'b1;
            tick(4);
            r1 = int'(out);
            read_enable = 1'b0;
            tick(SETTLE);
            read_enable = 1'b1;
            tick(4);
            r2 = int'(out);
            read_enable = 1'b0;
            tick(2);
            check("rd_coincide", r1 + r2, exp_sum);
        end

        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                3:       glitch(1'($urandom_range(0, 1)), int'($urandom_range(1, CYC / 2)));
                default: do_read("rand_read");
            endcase
        end
        do_read("rand_final");

        for (int k = 0; k < 130; k++) move_fwd();
`ifdef ROTARY_ENC_SATURATE_EN
        ovf_exp = 127;
`else
        ovf_exp = -126;
`endif
        check("ovf_model", m_acc, ovf_exp);
        do_read("ovf");

        // Reset mid-debounce must drop the pending CK edge.
        if (m_ck) move(1'b0, 1'b0);
        do_read("pre_rst_mid");
        ck = 1'b1;
        tick(CYC / 2);
        do_reset(1'b0, 1'b0);
        check("rst_mid_out", int'(out), 0);
        tick(SETTLE);
        do_read("rst_mid");

        // Lines high at reset release produce one step once debounced.
        do_reset(1'b1, 1'b1);
        move(1'b1, 1'b1);
        do_read("rst_high");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
